// File: rtl/demosaic_pkg.sv
//------------------------------------------------------------------------------
// Module  : demosaic_pkg
// Brief   : Shared width, rounding and saturation-bound helpers for the
//           demosaic multiplier pipeline.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demosaic_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 6;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Half an LSB of the shifted result, so that ties round toward +inf.
    function automatic logic [63:0] round_const(input int shift);
        return (shift > 0) ? (64'd1 << (shift - 1)) : 64'd0;
    endfunction

    function automatic logic [63:0] sat_umax(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_smax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_smin(input int w);
        return ~sat_smax(w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/demosaic_mul_round_sat.sv
//------------------------------------------------------------------------------
// Module  : demosaic_mul_round_sat
// Brief   : Combinational round-half-up, right shift and narrowing of the full
//           product. Saturation only when DEMOSAIC_MUL_SAT_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demosaic_mul_round_sat
    import demosaic_pkg::*;
#(
    parameter int P          = 28,
    parameter int DOUT_WIDTH = 27,
    parameter int IS_SIGNED  = 0,
    parameter int SHIFT      = 0
) (
    input  logic [P-1:0]          prod,
    output logic [DOUT_WIDTH-1:0] res,
    output logic                  sat
);

    // Headroom of DOUT_WIDTH+1 bits keeps the rounding add exact and leaves
    // room for a straightforward range test on the upper bits.
    localparam int c_ew = P + DOUT_WIDTH + 1;

    logic              w_sign;
    logic [c_ew-1:0]   w_ext;
    logic [c_ew-1:0]   w_sum;
    logic [c_ew-1:0]   w_shr;

    assign w_sign = (IS_SIGNED != 0) && prod[P-1];
    assign w_ext  = {{(DOUT_WIDTH + 1){w_sign}}, prod};
    assign w_sum  = w_ext + c_ew'(round_const(SHIFT));

    if (IS_SIGNED != 0) begin : g_ashr
        assign w_shr = $unsigned($signed(w_sum) >>> SHIFT);
    end else begin : g_lshr
        assign w_shr = w_sum >> SHIFT;
    end

`ifdef DEMOSAIC_MUL_SAT_EN
    if (IS_SIGNED != 0) begin : g_sat_s
        logic w_in_range;
        assign w_in_range = (&w_shr[c_ew-1:DOUT_WIDTH-1]) | ~(|w_shr[c_ew-1:DOUT_WIDTH-1]);
        assign sat = ~w_in_range;
        assign res = w_in_range        ? w_shr[DOUT_WIDTH-1:0] :
                     w_shr[c_ew-1]     ? DOUT_WIDTH'(sat_smin(DOUT_WIDTH)) :
                                         DOUT_WIDTH'(sat_smax(DOUT_WIDTH));
    end else begin : g_sat_u
        assign sat = |w_shr[c_ew-1:DOUT_WIDTH];
        assign res = sat ? DOUT_WIDTH'(sat_umax(DOUT_WIDTH)) : w_shr[DOUT_WIDTH-1:0];
    end
`else
    logic w_unused_hi;
    assign w_unused_hi = ^w_shr[c_ew-1:DOUT_WIDTH];
    assign sat         = 1'b0;
    assign res         = w_shr[DOUT_WIDTH-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/demosaic_mul_pipe.sv
//------------------------------------------------------------------------------
// Module  : demosaic_mul_pipe
// Brief   : Pipelined valid/ready multiplier with rounding shift; optional
//           saturation and sticky overflow via DEMOSAIC_MUL_SAT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demosaic_mul_pipe
    import demosaic_pkg::*;
#(
    parameter int DIN0_WIDTH = 20,
    parameter int DIN1_WIDTH = 8,
    parameter int DOUT_WIDTH = 27,
    parameter int NUM_STAGE  = 3,
    parameter int IS_SIGNED  = 0,
    parameter int SHIFT      = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  ovf_clr,
    output logic                  ovf_sticky
);

    localparam int c_p = prod_width(DIN0_WIDTH, DIN1_WIDTH);

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
        $error("demosaic_mul_pipe: NUM_STAGE out of range");
    end

    logic                  w_stall;
    logic [c_p-1:0]        w_a;
    logic [c_p-1:0]        w_b;
    logic [c_p-1:0]        w_prod;
    logic [c_p-1:0]        w_last;
    logic                  w_last_vld;
    logic [NUM_STAGE-1:0]  w_vld_next;
    logic [NUM_STAGE-1:0]  r_vld;
    logic [DOUT_WIDTH-1:0] w_res;
    logic                  w_sat;
    logic [DOUT_WIDTH-1:0] r_dout;

    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_vld[NUM_STAGE-1];
    assign dout      = r_dout;

    // Operands extended to the full product width; the truncated P-bit
    // product is then exact in either signedness.
    if (IS_SIGNED != 0) begin : g_ext_s
        assign w_a = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
        assign w_b = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};
    end else begin : g_ext_u
        assign w_a = {{DIN1_WIDTH{1'b0}}, din0};
        assign w_b = {{DIN0_WIDTH{1'b0}}, din1};
    end
    assign w_prod = w_a * w_b;

    if (NUM_STAGE > 1) begin : g_pipe
        logic [c_p-1:0] r_pipe [NUM_STAGE-1];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                for (int i = 0; i < NUM_STAGE - 1; i++) r_pipe[i] <= '0;
            end else if (!w_stall) begin
                r_pipe[0] <= w_prod;
                for (int i = 1; i < NUM_STAGE - 1; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign w_last     = r_pipe[NUM_STAGE-2];
        assign w_vld_next = {r_vld[NUM_STAGE-2:0], in_valid};
    end else begin : g_direct
        assign w_last     = w_prod;
        assign w_vld_next = in_valid;
    end
    assign w_last_vld = w_vld_next[NUM_STAGE-1];

    demosaic_mul_round_sat #(
        .P          (c_p),
        .DOUT_WIDTH (DOUT_WIDTH),
        .IS_SIGNED  (IS_SIGNED),
        .SHIFT      (SHIFT)
    ) u_round_sat (
        .prod (w_last),
        .res  (w_res),
        .sat  (w_sat)
    );

    // Bubbles advance through the valid chain but leave dout untouched.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_vld  <= '0;
            r_dout <= '0;
        end else if (!w_stall) begin
            r_vld <= w_vld_next;
            if (w_last_vld) r_dout <= w_res;
        end
    end

`ifdef DEMOSAIC_MUL_SAT_EN
    logic r_ovf;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ovf <= 1'b0;
        end else if (!w_stall && w_last_vld && w_sat) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end
    assign ovf_sticky = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = ovf_clr ^ w_sat;
    assign ovf_sticky   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demosaic_mul_pipe.sv
//------------------------------------------------------------------------------
// Module  : tb_demosaic_mul_pipe
// Brief   : Self-checking bench: default unsigned instance plus a signed,
//           shifted instance, checked against an arithmetic reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demosaic_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [19:0] a0 = '0;
    logic [7:0]  b0 = '0;
    logic        iv0 = 1'b0, or0 = 1'b1, clr0 = 1'b0;
    logic        ir0, ov0, ovf0;
    logic [26:0] d0;

    logic [19:0] a1 = '0;
    logic [7:0]  b1 = '0;
    logic        iv1 = 1'b0, or1 = 1'b1, clr1 = 1'b0;
    logic        ir1, ov1, ovf1;
    logic [15:0] d1;

    int nerr = 0;
    int nchk = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 clk = ~clk;

    demosaic_mul_pipe u_dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .din0(a0), .din1(b0),
        .in_valid(iv0), .in_ready(ir0), .dout(d0), .out_valid(ov0),
        .out_ready(or0), .ovf_clr(clr0), .ovf_sticky(ovf0)
    );

    demosaic_mul_pipe #(
        .DIN0_WIDTH(20), .DIN1_WIDTH(8), .DOUT_WIDTH(16),
        .NUM_STAGE(2), .IS_SIGNED(1), .SHIFT(4)
    ) u_dut1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .din0(a1), .din1(b1),
        .in_valid(iv1), .in_ready(ir1), .dout(d1), .out_valid(ov1),
        .out_ready(or1), .ovf_clr(clr1), .ovf_sticky(ovf1)
    );

    // Unsigned 20x8, no shift, narrowed to 27 bits.
    function automatic logic [63:0] model0(input logic [19:0] a, input logic [7:0] b);
        longint p;
        p = longint'(a) * longint'(b);
`ifdef DEMOSAIC_MUL_SAT_EN
        if (p > 134217727) p = 134217727;
`else
        p = p % 134217728;
`endif
        return 64'(p);
    endfunction

    // Signed 20x8, round half up then divide by 16 (floor), narrowed to 16 bits.
    function automatic logic [63:0] model1(input logic [19:0] a, input logic [7:0] b);
        longint sa, sb, p, q;
        sa = longint'(a); if (a[19]) sa = sa - 1048576;
        sb = longint'(b); if (b[7])  sb = sb - 256;
        p = sa * sb + 8;
        q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
`ifdef DEMOSAIC_MUL_SAT_EN
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`endif
        return 64'(q & 65535);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any output handshake, then record accepted inputs.
    task automatic cycle(output bit acc0, output bit acc1);
        logic [63:0] e0, e1;
        #1;
        acc0 = iv0 && ir0 && rst_n;
        acc1 = iv1 && ir1 && rst_n;
        e0 = model0(a0, b0);
        e1 = model1(a1, b1);
        if (ov0 && or0) begin
            if (q0.size() > 0) check("dut0_data", {37'b0, d0}, q0.pop_front());
            else               check("dut0_spurious", 64'(ov0), 64'd0);
        end
        if (ov1 && or1) begin
            if (q1.size() > 0) check("dut1_data", {48'b0, d1}, q1.pop_front());
            else               check("dut1_spurious", 64'(ov1), 64'd0);
        end
        @(posedge clk);
        #1;
        if (acc0) q0.push_back(e0);
        if (acc1) q1.push_back(e1);
    endtask

    task automatic step();
        bit x, y;
        cycle(x, y);
    endtask

    initial begin
        bit   acc0, acc1;
        int   lat, nvalid, first, last, idx;
        logic [26:0] held;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_during", 64'(ir0), 64'd1);
        check("rst_out_valid_during", 64'(ov0), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(ov0), 64'd0);
        check("rst_dout", 64'(d0), 64'd0);
        check("rst_in_ready", 64'(ir0), 64'd1);
        check("rst_ovf", 64'(ovf0), 64'd0);
        check("rst_ovf1", 64'(ovf1), 64'd0);
        @(posedge clk);
        #1;

        // Basic product and latency
        a0 = 20'd1000; b0 = 8'd200; iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        lat = 1;
        while (!ov0 && lat < 10) begin step(); lat++; end
        check("basic_latency", 64'(lat), 64'd3);
        check("basic_dout", {37'b0, d0}, 64'h30D40);
        step();

        // Signed instance with rounding shift
        a1 = 20'hFFF9C; b1 = 8'd3; iv1 = 1'b1;
        step();
        a1 = 20'd40; b1 = 8'd2;
        step();
        iv1 = 1'b0;
        check("signed_neg_valid", 64'(ov1), 64'd1);
        check("signed_neg_dout", {48'b0, d1}, 64'hFFED);
        step();
        check("signed_pos_dout", {48'b0, d1}, 64'd5);
        step();

        // Overflow / wrap
        a0 = 20'hFFFFF; b0 = 8'hFF; iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        lat = 1;
        while (!ov0 && lat < 10) begin step(); lat++; end
        check("ovf_latency", 64'(lat), 64'd3);
`ifdef DEMOSAIC_MUL_SAT_EN
        check("ovf_dout", {37'b0, d0}, 64'h7FFFFFF);
        check("ovf_sticky_set", 64'(ovf0), 64'd1);
        step();
        check("ovf_sticky_hold", 64'(ovf0), 64'd1);
`else
        check("ovf_dout", {37'b0, d0}, 64'h7EFFF01);
        check("ovf_sticky_set", 64'(ovf0), 64'd0);
        step();
        check("ovf_sticky_hold", 64'(ovf0), 64'd0);
`endif
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        check("ovf_sticky_clr", 64'(ovf0), 64'd0);

        // Back-to-back stream
        nvalid = 0; first = -1; last = -1;
        for (int t = 0; t < 16; t++) begin
            iv0 = (t < 8); a0 = 20'(t); b0 = 8'(t + 1);
            #1;
            if (ov0) begin
                if (first < 0) first = t;
                last = t;
                nvalid++;
            end
            step();
        end
        check("stream_count", 64'(nvalid), 64'd8);
        check("stream_first", 64'(first), 64'd3);
        check("stream_contig", 64'(last - first), 64'd7);

        // Stream with a four-cycle downstream stall
        idx = 0;
        held = '0;
        for (int t = 0; t < 40; t++) begin
            if (idx >= 8 && q0.size() == 0 && t > 9) break;
            iv0 = (idx < 8); a0 = 20'(idx + 3); b0 = 8'(idx + 4);
            or0 = !(t >= 5 && t < 9);
            #1;
            if (t == 5) begin
                held = d0;
                check("stall_out_valid", 64'(ov0), 64'd1);
            end
            if (t >= 5 && t < 9) begin
                check("stall_in_ready", 64'(ir0), 64'd0);
                check("stall_dout_stable", {37'b0, d0}, {37'b0, held});
            end
            cycle(acc0, acc1);
            if (acc0) idx++;
        end
        or0 = 1'b1; iv0 = 1'b0;
        check("stall_drained", 64'(q0.size()), 64'd0);

        // Randomised traffic on both instances
        for (int t = 0; t < 300; t++) begin
            iv0 = ($urandom_range(0, 9) < 7);
            iv1 = ($urandom_range(0, 9) < 7);
            a0  = ($urandom_range(0, 3) == 0) ? 20'hFFFFF - 20'($urandom_range(0, 4095)) : 20'($urandom);
            b0  = 8'($urandom);
            a1  = 20'($urandom);
            b1  = 8'($urandom);
            or0 = ($urandom_range(0, 3) != 0);
            or1 = ($urandom_range(0, 3) != 0);
            step();
        end
        iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
        repeat (8) step();
        check("rand_drained0", 64'(q0.size()), 64'd0);
        check("rand_drained1", 64'(q1.size()), 64'd0);

        // Reset while items are in flight
        a0 = 20'd7; b0 = 8'd9; iv0 = 1'b1;
        step();
        a0 = 20'd11;
        step();
        iv0 = 1'b0;
        step();
        check("midrst_valid_before", 64'(ov0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid_drop", 64'(ov0), 64'd0);
        q0.delete();
        q1.delete();
        repeat (2) step();
        rst_n = 1'b1;
        nvalid = 0;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (ov0) nvalid++;
            step();
        end
        check("midrst_no_stale", 64'(nvalid), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
